// File: rtl/disp_scan_hms.sv
// Six-digit multiplexed common-anode 7-segment driver for the HH:MM:SS clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module disp_scan_hms #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable1hz,
  input  logic       edit_h,
  input  logic [1:0] bcd_h_msd,
  input  logic [3:0] bcd_h_lsd,
  input  logic [2:0] bcd_m_msd,
  input  logic [3:0] bcd_m_lsd,
  input  logic [2:0] bcd_s_msd,
  input  logic [3:0] bcd_s_lsd,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             phase_q, phase_d;
  logic             first_q;
  logic [23:0]      snap_q, snap_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic        wrap;
  logic [23:0] live;
  logic [23:0] cur;
  logic [3:0]  val;

  assign wrap = (div_q == CNT_W'(SCAN_DIV - 1));
  assign live = {2'b00, bcd_h_msd, bcd_h_lsd, 1'b0, bcd_m_msd, bcd_m_lsd,
                 1'b0, bcd_s_msd, bcd_s_lsd};
  // On the very first cycle the snapshot register is still empty, so show the live digits
  assign cur  = first_q ? live : snap_q;

  always_comb begin
    val = 4'h0;
    case (idx_q)
      3'd0:    val = cur[23:20];
      3'd1:    val = cur[19:16];
      3'd2:    val = cur[15:12];
      3'd3:    val = cur[11:8];
      3'd4:    val = cur[7:4];
      default: val = cur[3:0];
    endcase
  end

  always_comb begin
    div_d   = wrap ? '0 : div_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    snap_d  = (first_q || (wrap && idx_q == 3'd5)) ? live : snap_q;
    phase_d = phase_q ^ enable1hz;
    an_d    = ~(6'b100000 >> idx_q);
    case (val)
      4'd0:    seg_d = 7'h40;
      4'd1:    seg_d = 7'h79;
      4'd2:    seg_d = 7'h24;
      4'd3:    seg_d = 7'h30;
      4'd4:    seg_d = 7'h19;
      4'd5:    seg_d = 7'h12;
      4'd6:    seg_d = 7'h02;
      4'd7:    seg_d = 7'h78;
      4'd8:    seg_d = 7'h00;
      4'd9:    seg_d = 7'h10;
      default: seg_d = 7'h3F;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 3'd0 && val == 4'd0) seg_d = 7'h7F;
`endif
    if (edit_h && !phase_q && idx_q <= 3'd1) seg_d = 7'h7F;
    dp_d    = ~(phase_q && (idx_q == 3'd1 || idx_q == 3'd3));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q   <= '0;
      idx_q   <= 3'd0;
      phase_q <= 1'b0;
      first_q <= 1'b1;
      snap_q  <= '0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      first_q <= 1'b0;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an_n  = an_q;
  assign seg_n = seg_q;
  assign dp_n  = dp_q;

endmodule

// File: tb/tb_disp_scan_hms.sv
// Bench for disp_scan_hms: frame-level reference model plus directed and random stimulus.
module tb_disp_scan_hms;
  localparam int D = 4;
  localparam int FRAME = 6 * D;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable1hz = 1'b0;
  logic       edit_h = 1'b0;
  logic [1:0] bcd_h_msd = 2'd2;
  logic [3:0] bcd_h_lsd = 4'd3;
  logic [2:0] bcd_m_msd = 3'd5;
  logic [3:0] bcd_m_lsd = 4'd9;
  logic [2:0] bcd_s_msd = 3'd5;
  logic [3:0] bcd_s_lsd = 4'd8;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int n_checks = 0;
  int n_fail = 0;

  disp_scan_hms #(.SCAN_DIV(D), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .enable1hz(enable1hz), .edit_h(edit_h),
    .bcd_h_msd(bcd_h_msd), .bcd_h_lsd(bcd_h_lsd), .bcd_m_msd(bcd_m_msd),
    .bcd_m_lsd(bcd_m_lsd), .bcd_s_msd(bcd_s_msd), .bcd_s_lsd(bcd_s_lsd),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference model: n = rising edges since reset release; slot and frame follow by division
  int n = 0;
  int pulses = 0;
  bit mvalid = 0;
  int snaps [int];
  logic [5:0] e_an = 6'h3F;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;

  function automatic int digits_now();
    return (int'(bcd_h_msd) << 20) | (int'(bcd_h_lsd) << 16) | (int'(bcd_m_msd) << 12) |
           (int'(bcd_m_lsd) << 8) | (int'(bcd_s_msd) << 4) | int'(bcd_s_lsd);
  endfunction

  initial begin
    int idx, f, v;
    logic [5:0] top;
    forever begin
      @(posedge clock);
      if (!reset) begin
        n = 0; pulses = 0; snaps.delete();
        e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        n++;
        if (n == 1 || n % FRAME == 0) snaps[n / FRAME] = digits_now();
        idx = ((n - 1) / D) % 6;
        f = (n - 1) / FRAME;
        v = (snaps[f] >> (4 * (5 - idx))) & 15;
        top = 6'b100000;
        e_an = ~(top >> idx);
        e_seg = seg_of(v);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 0 && v == 0) e_seg = 7'h7F;
`endif
        if (edit_h && (pulses % 2 == 0) && idx < 2) e_seg = 7'h7F;
        e_dp = !((pulses % 2 == 1) && (idx == 1 || idx == 3));
        if (enable1hz) pulses++;
      end
      mvalid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (mvalid) begin
        chk("an_n", int'(an_n), int'(e_an));
        chk("seg_n", int'(seg_n), int'(e_seg));
        chk("dp_n", int'(dp_n), int'(e_dp));
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clock);
  endtask

  initial begin
    logic [6:0] seq_seg [6];
    logic [5:0] seq_an [6];
    seq_seg[0] = 7'h24; seq_seg[1] = 7'h30; seq_seg[2] = 7'h12;
    seq_seg[3] = 7'h10; seq_seg[4] = 7'h12; seq_seg[5] = 7'h00;
    seq_an[0] = 6'h1F; seq_an[1] = 6'h2F; seq_an[2] = 6'h37;
    seq_an[3] = 6'h3B; seq_an[4] = 6'h3D; seq_an[5] = 6'h3E;

    tick(3);
    chk("reset_an", int'(an_n), 'h3F);
    chk("reset_seg", int'(seg_n), 'h7F);
    chk("reset_dp", int'(dp_n), 1);
    reset = 1'b1;
    tick(1);
    // first frame: scan order and decode; s_lsd changes mid-frame
    for (int k = 0; k < 6; k++) begin
      chk("scan_an", int'(an_n), int'(seq_an[k]));
      chk("decode_seg", int'(seg_n), int'(seq_seg[k]));
      if (k == 2) bcd_s_lsd = 4'd9;
      tick(D);
    end
    chk("wrap_an", int'(an_n), 'h1F);
    tick(5 * D);
    chk("next_frame_an", int'(an_n), 'h3E);
    chk("next_frame_seg", int'(seg_n), 'h10);

    // colon
    enable1hz = 1'b1; tick(1); enable1hz = 1'b0;
    tick(2 * FRAME);
    enable1hz = 1'b1; tick(1); enable1hz = 1'b0;
    tick(FRAME);

    // hour blink, hour 12
    bcd_h_msd = 2'd1; bcd_h_lsd = 4'd2; edit_h = 1'b1;
    tick(2 * FRAME);
    enable1hz = 1'b1; tick(1); enable1hz = 1'b0;
    tick(2 * FRAME);
    edit_h = 1'b0;

    // invalid digit, then reset at idx 3
    bcd_m_lsd = 4'd12;
    bcd_h_msd = 2'd0; bcd_h_lsd = 4'd7;
    tick(2 * FRAME);
    for (int g = 0; g < 2 * FRAME && (((n - 1) / D) % 6) != 3; g++) tick(1);
    chk("pre_reset_idx", ((n - 1) / D) % 6, 3);
    reset = 1'b0; tick(1);
    chk("midreset_an", int'(an_n), 'h3F);
    chk("midreset_seg", int'(seg_n), 'h7F);
    reset = 1'b1; tick(1);
    chk("restart_an", int'(an_n), 'h1F);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_seg", int'(seg_n), 'h7F);
`else
    chk("lz_seg", int'(seg_n), 'h40);
`endif
    tick(D);
    chk("hour_units_seg", int'(seg_n), 'h78);
    tick(2 * FRAME);

    // randomized phase
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        bcd_h_msd = 2'($urandom_range(0, 3));
        bcd_h_lsd = 4'($urandom_range(0, 15));
        bcd_m_msd = 3'($urandom_range(0, 7));
        bcd_m_lsd = 4'($urandom_range(0, 15));
        bcd_s_msd = 3'($urandom_range(0, 7));
        bcd_s_lsd = 4'($urandom_range(0, 15));
      end
      enable1hz = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) edit_h = ~edit_h;
      reset = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    reset = 1'b1; enable1hz = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
